// File: rtl/input_conditioner.sv
// Debounces WIDTH switch inputs: 2-flop sync, per-channel 4-state qualifier,
// rising-edge strobes with mutual-exclusion suppression across the coin group.

module input_conditioner_ch #(
   parameter int DB_CYCLES = 3,
   parameter int CNT_W     = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_DISARM} state_t;

   // Count value at which one more agreeing sample completes qualification.
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

   logic [1:0]       r_sync;
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_level;
   logic             w_sample;

   assign w_sample = r_sync[1];
   assign o_level  = r_level;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= '0;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_raw};
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_DISARM);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_rise      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_sample) begin
               if (r_cnt == LP_LAST) begin
                  w_state_nxt = S_HIGH;
                  w_cnt_nxt   = '0;
                  o_rise      = 1'b1;
               end else begin
                  w_state_nxt = S_ARM;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         S_ARM: begin
            if (!w_sample) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
               o_rise      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (!w_sample) begin
               if (r_cnt == LP_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_DISARM;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         S_DISARM: begin
            // Bounce back to high restores HIGH silently: no new press.
            if (w_sample) begin
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end
endmodule

module input_conditioner #(
   parameter int               WIDTH     = 7,
   parameter int               DB_CYCLES = 3,
   parameter int               CNT_W     = 4,
   parameter logic [WIDTH-1:0] EXCL_MASK = WIDTH'(7'b1110000)
) (
   input  logic             CLOCK,
   input  logic             nRESET,
   input  logic [WIDTH-1:0] RAW_IN,
   output logic [WIDTH-1:0] LEVEL,
   output logic [WIDTH-1:0] PULSE,
   output logic             EXCL_ERR
);
   logic [WIDTH-1:0] w_rise, w_excl, w_pulse;
   logic             w_multi;
   logic [WIDTH-1:0] r_pulse;
   logic             r_err;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      input_conditioner_ch #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_ch (
         .i_clk   (CLOCK),
         .i_rst_n (nRESET),
         .i_raw   (RAW_IN[g]),
         .o_level (LEVEL[g]),
         .o_rise  (w_rise[g])
      );
   end

   // More than one bit set in the exclusive group <=> clearing the lowest set bit leaves something.
   assign w_excl  = w_rise & EXCL_MASK;
   assign w_multi = |(w_excl & (w_excl - 1'b1));
   assign w_pulse = w_multi ? (w_rise & ~EXCL_MASK) : w_rise;

   always_ff @(posedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         r_pulse <= '0;
         r_err   <= 1'b0;
      end else begin
         r_pulse <= w_pulse;
         r_err   <= w_multi;
      end
   end

   assign PULSE    = r_pulse;
   assign EXCL_ERR = r_err;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed + random bench for input_conditioner; reference model tracks per-channel
// run lengths of samples disagreeing with the accepted level.

module tb_input_conditioner;
   localparam int              W  = 7;
   localparam int              DB = 3;
   localparam logic [W-1:0]    XM = 7'b1110000;

   logic         CLOCK = 1'b0;
   logic         nRESET;
   logic [W-1:0] RAW_IN;
   logic [W-1:0] LEVEL, PULSE;
   logic         EXCL_ERR;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] m_s1, m_s2, m_lvl, m_pul;
   logic         m_err;
   int           m_run [W];

   always #5 CLOCK = ~CLOCK;

   input_conditioner #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(4), .EXCL_MASK(XM)) dut (
      .CLOCK    (CLOCK),
      .nRESET   (nRESET),
      .RAW_IN   (RAW_IN),
      .LEVEL    (LEVEL),
      .PULSE    (PULSE),
      .EXCL_ERR (EXCL_ERR)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0; m_err = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   // One rising edge of the reference: a level change is accepted after DB
   // consecutive samples that disagree with the current level.
   task automatic m_step();
      logic [W-1:0] s, rise;
      s = m_s2; m_s2 = m_s1; m_s1 = RAW_IN; rise = '0;
      for (int i = 0; i < W; i++) begin
         if (s[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] >= DB) begin
               m_lvl[i] = s[i];
               m_run[i] = 0;
               rise[i]  = s[i];
            end
         end else begin
            m_run[i] = 0;
         end
      end
      if ($countones(rise & XM) >= 2) begin
         m_pul = rise & ~XM; m_err = 1'b1;
      end else begin
         m_pul = rise; m_err = 1'b0;
      end
   endtask

   // Called at a negedge: drive, take one rising edge, compare at the next negedge.
   task automatic cyc(input logic [W-1:0] raw);
      RAW_IN = raw;
      @(posedge CLOCK);
      m_step();
      @(negedge CLOCK);
      chk("model_level", LEVEL, m_lvl);
      chk("model_pulse", PULSE, m_pul);
      chk("model_err", {6'b0, EXCL_ERR}, {6'b0, m_err});
   endtask

   // Called at a negedge: assert reset, check the asynchronous clear, release
   // at the next negedge so the following rising edge is edge 1.
   task automatic do_reset(input logic [W-1:0] raw);
      nRESET = 1'b0;
      RAW_IN = raw;
      #1;
      chk("rst_level", LEVEL, '0);
      chk("rst_pulse", PULSE, '0);
      chk("rst_err", {6'b0, EXCL_ERR}, '0);
      m_reset();
      @(negedge CLOCK);
      nRESET = 1'b1;
   endtask

   initial begin
      logic [W-1:0] raw;
      int hold;
      nRESET = 1'b0;
      RAW_IN = '0;
      m_reset();
      @(negedge CLOCK);

      // Inputs high through reset are new presses.
      do_reset(7'h0F);
      repeat (4) begin
         cyc(7'h0F);
         chk("r030_quiet_lvl", LEVEL, '0);
         chk("r030_quiet_pul", PULSE, '0);
      end
      cyc(7'h0F);
      chk("r030_pulse", PULSE, 7'h0F);
      chk("r030_level", LEVEL, 7'h0F);
      cyc(7'h0F);
      chk("r030_pulse_once", PULSE, '0);

      // Single coin press, then a second coin while the first is held.
      do_reset('0);
      repeat (4) begin
         cyc(7'h10);
         chk("r031_quiet", PULSE, '0);
      end
      cyc(7'h10);
      chk("r031_pulse", PULSE, 7'h10);
      chk("r031_level", LEVEL, 7'h10);
      chk("r031_err", {6'b0, EXCL_ERR}, '0);
      repeat (5) begin
         cyc(7'h10);
         chk("r031_hold", PULSE, '0);
      end
      repeat (4) cyc(7'h30);
      cyc(7'h30);
      chk("r025_pulse", PULSE, 7'h20);
      chk("r025_err", {6'b0, EXCL_ERR}, '0);

      // Short glitch on a low channel is ignored.
      do_reset('0);
      repeat (2) cyc(7'h01);
      repeat (8) begin
         cyc('0);
         chk("r032_level", LEVEL, '0);
         chk("r032_pulse", PULSE, '0);
      end

      // Short dropout on a high channel is ignored.
      repeat (5) cyc(7'h02);
      cyc(7'h02);
      chk("r033_setup", LEVEL, 7'h02);
      repeat (2) cyc('0);
      repeat (6) begin
         cyc(7'h02);
         chk("r033_level", LEVEL, 7'h02);
         chk("r033_pulse", PULSE, '0);
      end

      // Two coins plus START together.
      do_reset('0);
      repeat (4) cyc(7'h61);
      cyc(7'h61);
      chk("r034_pulse", PULSE, 7'h01);
      chk("r034_err", {6'b0, EXCL_ERR}, 7'h01);
      chk("r034_level", LEVEL, 7'h61);
      cyc(7'h61);
      chk("r034_err_once", {6'b0, EXCL_ERR}, '0);

      // Reset mid-qualification restarts from scratch.
      do_reset('0);
      repeat (4) cyc(7'h04);
      do_reset(7'h04);
      repeat (4) begin
         cyc(7'h04);
         chk("r035_quiet", PULSE, '0);
      end
      cyc(7'h04);
      chk("r035_pulse", PULSE, 7'h04);

      // Random bouncing inputs, occasional reset.
      do_reset('0);
      raw = '0;
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            raw  = raw ^ W'($urandom & $urandom);
            hold = $urandom_range(1, 6);
         end
         hold--;
         if ($urandom_range(0, 499) == 0) do_reset(raw);
         cyc(raw);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
